// File: rtl/block_packer.sv
// block_packer: packs 32-bit stream words into zero-padded 128-bit blocks for input_fifo
// and reports per-message byte and block counts.
module block_packer #(
  parameter int width  = 128,
  parameter int word_w = 32,
  parameter int len_w  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [word_w-1:0] s_data,
  input  logic              s_last,
  input  logic [1:0]        s_bytes,
  input  logic              fifo_full,
  output logic              fifo_w_en,
  output logic [width-1:0]  fifo_data,
  output logic              msg_done,
  output logic [len_w-1:0]  msg_bytes,
  output logic [15:0]       blk_count,
  output logic              busy
);
  typedef enum logic {COLLECT, PUSH} state_t;
  state_t             r_state;
  logic               r_ready;
  logic [1:0]         r_idx;
  logic [width-1:0]   r_blk;
  logic               r_last_pending;
  logic               r_done;
  logic [len_w-1:0]   r_bytes;
  logic [len_w-1:0]   r_msg_bytes;
  logic [15:0]        r_blks;
  logic [15:0]        r_blk_count;
  logic               w_acc;
  logic               w_part;
  logic [word_w-1:0]  w_word;
  logic [len_w-1:0]   w_add;
  // rst gating keeps the handshake and write strobe quiet during the reset cycle itself
  assign s_ready   = r_ready && !rst;
  assign fifo_w_en = (r_state == PUSH) && !fifo_full && !rst;
  assign fifo_data = r_blk;
  assign msg_done  = r_done;
  assign msg_bytes = r_msg_bytes;
  assign blk_count = r_blk_count;
  assign busy      = (r_idx != 2'd0) || (r_state == PUSH);
  assign w_acc     = s_valid && s_ready;
  assign w_part    = s_last && (s_bytes != 2'd0);
  assign w_word    = w_part ? (s_data & ~({word_w{1'b1}} >> {s_bytes, 3'd0})) : s_data;
  assign w_add     = w_part ? len_w'(s_bytes) : len_w'(3'd4);
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= COLLECT;
      r_ready        <= 1'b1;
      r_idx          <= 2'd0;
      r_blk          <= '0;
      r_last_pending <= 1'b0;
      r_done         <= 1'b0;
      r_bytes        <= '0;
      r_msg_bytes    <= '0;
      r_blks         <= '0;
      r_blk_count    <= '0;
    end else begin
      r_done <= fifo_w_en && r_last_pending;
      if (r_state == COLLECT) begin
        if (r_done) r_blks <= '0;
        if (w_acc) begin
          r_blk[{~r_idx, 5'd0} +: word_w] <= w_word;
          r_idx       <= r_idx + 2'd1;
          r_bytes     <= (r_done ? '0 : r_bytes) + w_add;
          r_msg_bytes <= '0;
          r_blk_count <= '0;
          if (s_last) r_last_pending <= 1'b1;
          if (r_idx == 2'd3 || s_last) begin
            r_state <= PUSH;
            r_ready <= 1'b0;
          end
        end else if (r_done) begin
          r_bytes <= '0;
        end
      end else if (fifo_w_en) begin
        r_blk          <= '0;
        r_idx          <= 2'd0;
        r_state        <= COLLECT;
        r_ready        <= 1'b1;
        r_blks         <= r_blks + 16'd1;
        r_last_pending <= 1'b0;
        if (r_last_pending) begin
          r_msg_bytes <= r_bytes;
          r_blk_count <= r_blks + 16'd1;
        end
      end
    end
  end
endmodule
